// File: rtl/gate_vec_decoder.sv
`default_nettype none
// ============================================================================
// Module   : gate_vec_decoder
// Brief    : Serially rebuilds a vector from its circular neighbour-XOR word
//            and seed bit; flags inconsistent circular parity. Optional
//            both/any regeneration check enabled by macro CROSS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gate_vec_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_diff,
  input  logic             in_seed,
  input  logic [WIDTH-2:0] in_both,
  input  logic [WIDTH-2:0] in_any,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_parity_err,
  output logic             out_check_err
);

  localparam int IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-2:0] diff_q;
  logic [WIDTH-1:0] vec_q;
  logic [WIDTH-1:0] vec_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             parity_q;
  logic             check_q;
  logic             check_d;

  // The top diff bit only closes the ring, so it feeds parity and is not stored.
  always_comb begin
    vec_d = vec_q;
    for (int i = 1; i < WIDTH; i++) begin
      if (idx_q == IDXW'(i)) vec_d[i] = vec_q[i-1] ^ diff_q[i-1];
    end
  end

`ifdef CROSS_CHECK_EN
  logic [WIDTH-2:0] both_q;
  logic [WIDTH-2:0] any_q;
  logic [WIDTH-2:0] both_gen;
  logic [WIDTH-2:0] any_gen;

  assign both_gen = vec_d[WIDTH-1:1] & vec_d[WIDTH-2:0];
  assign any_gen  = vec_d[WIDTH-1:1] | vec_d[WIDTH-2:0];
  assign check_d  = (both_gen != both_q) || (any_gen != any_q);
`else
  logic unused_cross;
  assign unused_cross = ^{in_both, in_any};
  assign check_d      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      diff_q      <= '0;
      vec_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      parity_q    <= 1'b0;
      check_q     <= 1'b0;
`ifdef CROSS_CHECK_EN
      both_q      <= '0;
      any_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            diff_q     <= in_diff[WIDTH-2:0];
            vec_q      <= {{(WIDTH-1){1'b0}}, in_seed};
            parity_q   <= ^in_diff;
            check_q    <= 1'b0;
            idx_q      <= IDXW'(1);
            in_ready_q <= 1'b0;
            state_q    <= S_DECODE;
`ifdef CROSS_CHECK_EN
            both_q     <= in_both;
            any_q      <= in_any;
`endif
          end
        end
        S_DECODE: begin
          vec_q <= vec_d;
          if (idx_q == IDXW'(WIDTH-1)) begin
            check_q     <= check_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_vec        = vec_q;
  assign out_parity_err = parity_q;
  assign out_check_err  = check_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_vec_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_vec_decoder
// Brief    : Directed and random words against a behavioural ring-decode model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_vec_decoder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_diff = '0;
  logic         in_seed = 1'b0;
  logic [W-2:0] in_both = '0;
  logic [W-2:0] in_any = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_vec;
  logic         out_parity_err;
  logic         out_check_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  gate_vec_decoder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_diff(in_diff), .in_seed(in_seed), .in_both(in_both), .in_any(in_any),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_parity_err(out_parity_err), .out_check_err(out_check_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_vec(input logic [W-1:0] d, input logic s);
    logic [W-1:0] v;
    v[0] = s;
    for (int i = 1; i < W; i++) v[i] = v[i-1] ^ d[i-1];
    return v;
  endfunction

  function automatic logic [W-2:0] model_both(input logic [W-1:0] v);
    logic [W-2:0] r;
    for (int i = 0; i < W-1; i++) r[i] = v[i+1] & v[i];
    return r;
  endfunction

  function automatic logic [W-2:0] model_any(input logic [W-1:0] v);
    logic [W-2:0] r;
    for (int i = 0; i < W-1; i++) r[i] = v[i+1] | v[i];
    return r;
  endfunction

  function automatic logic model_check(input logic [W-1:0] v, input logic [W-2:0] b,
                                       input logic [W-2:0] a);
`ifdef CROSS_CHECK_EN
    return (b != model_both(v)) || (a != model_any(v));
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the output handshake.
  task automatic send(input logic [W-1:0] d, input logic s, input logic [W-2:0] b,
                      input logic [W-2:0] a, input int hold, output int acc_cyc);
    logic [W-1:0] ev;
    int lat;
    ev = model_vec(d, s);
    in_diff = d; in_seed = s; in_both = b; in_any = a;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    chk("in_ready_idle", in_ready, 1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, W-1);
    chk("out_vec", out_vec, ev);
    chk("parity_err", out_parity_err, ($countones(d) % 2));
    chk("check_err", out_check_err, model_check(ev, b, a));
    if (hold > 0) begin
      in_valid = 1'b1;
      in_diff = ~d;
      in_seed = ~s;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_vec", out_vec, ev);
        chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
  endtask

  initial begin
    int acc;
    int prev_acc;
    logic [W-1:0] rd;
    logic         rs;
    logic [W-1:0] rv;
    logic [W-2:0] rb;
    logic [W-2:0] ra;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_parity", out_parity_err, 0);
    chk("rst_check", out_check_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(4'b0110, 1'b1, 3'b001, 3'b111, 0, acc);
    send(4'b0111, 1'b0, 3'b000, 3'b111, 0, acc);
    send(4'b0110, 1'b1, 3'b011, 3'b111, 0, acc);
    send(4'b1001, 1'b1, 3'b000, 3'b000, 5, acc);

    // Abort a word mid-decode with reset.
    in_diff = 4'b1010; in_seed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_out_vec", out_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rstmid_no_output", out_valid, 0);
    end
    send(4'b0000, 1'b1, 3'b111, 3'b111, 0, acc);

    prev_acc = 0;
    for (int k = 0; k < 24; k++) begin
      rd = W'($urandom);
      rs = 1'($urandom);
      rv = model_vec(rd, rs);
      rb = model_both(rv);
      ra = model_any(rv);
      if ($urandom_range(0, 2) == 0) rb = rb ^ (W-1)'($urandom_range(1, (1 << (W-1)) - 1));
      if ($urandom_range(0, 2) == 0) ra = ra ^ (W-1)'($urandom_range(1, (1 << (W-1)) - 1));
      send(rd, rs, rb, ra, (k % 6 == 5) ? 2 : 0, acc);
      if (k > 0 && (k % 6 != 0)) chk("b2b_spacing", acc - prev_acc, W+1);
      prev_acc = acc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
